// File: rtl/quokka_internal_reset_gen_pkg.sv
// quokka_internal_reset_gen_pkg: shared FSM state encoding and counter-sizing helper
package quokka_internal_reset_gen_pkg;

    typedef enum logic [1:0] {
        POR    = 2'd0,
        IDLE   = 2'd1,
        ASSERT = 2'd2,
        SETTLE = 2'd3
    } state_t;

    // Smallest r with 2**r >= v, used to size the shared timing counter.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/quokka_down_counter.sv
// quokka_down_counter: loadable down counter with zero flag, holds at zero
//   clk      in  system clock
//   rst_n    in  async active-low reset, loads RST_VAL
//   load     in  load load_val this edge (takes priority over decrement)
//   load_val in  value to load
//   zero     out counter is zero
module quokka_down_counter #(
    parameter int             W       = 4,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= RST_VAL;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/quokka_internal_reset_gen.sv
// quokka_internal_reset_gen: power-on and request-driven internal reset pulse generator
//   clk            in  system clock
//   rst_n          in  async active-low external reset
//   reset_request  in  level request for an internal reset pulse
//   internal_reset out active-high reset pulse to board-signal logic
//   request_ack    out one-cycle pulse, first cycle of an accepted request pulse
//   busy           out high whenever not idle
//   reset_count    out saturating count of request-driven pulses
module quokka_internal_reset_gen
    import quokka_internal_reset_gen_pkg::*;
#(
    parameter int POR_CYCLES    = 16,
    parameter int HOLD_CYCLES   = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             reset_request,
    output logic             internal_reset,
    output logic             request_ack,
    output logic             busy,
    output logic [CNT_W-1:0] reset_count
);

    localparam int MAX_C = (POR_CYCLES > HOLD_CYCLES)
                         ? ((POR_CYCLES > SETTLE_CYCLES) ? POR_CYCLES : SETTLE_CYCLES)
                         : ((HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES);
    localparam int CW = (clog2(MAX_C + 1) < 1) ? 1 : clog2(MAX_C + 1);
    localparam logic [CW-1:0] POR_LD  = CW'(POR_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] SET_LD  = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam bit NO_SETTLE = (SETTLE_CYCLES == 0);

    if (POR_CYCLES < 1 || HOLD_CYCLES < 1 || SETTLE_CYCLES < 0 || CNT_W < 1
        || (1 << CW) <= MAX_C) begin : g_bad_params
        $error("quokka_internal_reset_gen: illegal timing parameters or counter width");
    end

    state_t        state, nxt_state;
    logic          zero, load, take, pending, pend_eff;
    logic [CW-1:0] load_val;

    quokka_down_counter #(.W(CW), .RST_VAL(POR_LD)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .zero     (zero)
    );

    // A request seen in the last settle cycle counts as pending, so a held
    // level request repeats with no idle gap.
    always_comb begin
        pend_eff  = pending | reset_request;
        nxt_state = (state == POR)    ? (zero ? (NO_SETTLE ? IDLE : SETTLE) : POR)
                  : (state == IDLE)   ? (reset_request ? ASSERT : IDLE)
                  : (state == ASSERT) ? (zero ? (NO_SETTLE ? IDLE : SETTLE) : ASSERT)
                  :                     (zero ? (pend_eff ? ASSERT : IDLE) : SETTLE);
        take      = (nxt_state == ASSERT) && (state != ASSERT);
        load      = (nxt_state != state);
        load_val  = (nxt_state == ASSERT) ? HOLD_LD : SET_LD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= POR;
            internal_reset <= 1'b1;
            busy           <= 1'b1;
            request_ack    <= 1'b0;
            reset_count    <= '0;
            pending        <= 1'b0;
        end else begin
            state          <= nxt_state;
            internal_reset <= (nxt_state == POR) || (nxt_state == ASSERT);
            busy           <= (nxt_state != IDLE);
            request_ack    <= take;
            pending        <= (state == SETTLE) && !zero && pend_eff;
            if (take && !(&reset_count))
                reset_count <= reset_count + 1'b1;
        end
    end

endmodule
